// File: rtl/time_set_ctrl_pkg.sv
// Shared field codes, limits, FSM encoding and value helpers for the time-setting front end.
package time_set_ctrl_pkg;

   localparam logic [1:0] FIELD_SEC  = 2'b00;
   localparam logic [1:0] FIELD_MIN  = 2'b01;
   localparam logic [1:0] FIELD_HR   = 2'b10;
   localparam logic [1:0] FIELD_NONE = 2'b11;

   localparam logic [5:0] MAX_SEC_MIN = 6'd59;
   localparam logic [5:0] MAX_HR      = 6'd23;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EDIT_H = 3'd1,
      ST_EDIT_M = 3'd2,
      ST_EDIT_S = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   function automatic logic [5:0] field_max(input logic [1:0] field);
      return (field == FIELD_HR) ? MAX_HR : MAX_SEC_MIN;
   endfunction

   // One step up or down with wrap-around inside 0..max.
   function automatic logic [5:0] step_value(input logic [5:0] v, input logic [5:0] max, input logic up);
      if (up)
         return (v >= max) ? 6'd0 : v + 6'd1;
      else
         return (v == 6'd0 || v > max) ? max : v - 6'd1;
   endfunction

   // An out-of-range counter snapshot must never leak into the edit register.
   function automatic logic [5:0] clamp_value(input logic [5:0] v, input logic [5:0] max);
      return (v > max) ? 6'd0 : v;
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Per-button 2-FF synchronizer, stability counter and rising-edge press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DB_CNT_W        = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_pulse
);

   logic                r_sync1;
   logic                r_sync2;
   logic                r_stable;
   logic [DB_CNT_W-1:0] r_cnt;
   logic                r_pulse;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
         r_pulse  <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         // Any return to the accepted level restarts the stability window.
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
            r_pulse  <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Debounced button front end with an hours/minutes/seconds edit FSM driving the counter write port.
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DB_CNT_W        = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_set,
   input  logic       btn_cancel,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [5:0] q_seconds,
   input  logic [5:0] q_minutes,
   input  logic [4:0] q_hours,
   output logic       load,
   output logic [1:0] addrs,
   output logic [5:0] data_in,
   output logic       editing,
   output logic [1:0] edit_field
);

   localparam int BTN_SET    = 0;
   localparam int BTN_CANCEL = 1;
   localparam int BTN_UP     = 2;
   localparam int BTN_DOWN   = 3;

   logic [3:0] w_raw;
   logic [3:0] w_pulse;
   logic       w_set;
   logic       w_cancel;
   logic       w_up;
   logic       w_down;

   assign w_raw = {btn_down, btn_up, btn_cancel, btn_set};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_db
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_CNT_W        (DB_CNT_W)
         ) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_btn   (w_raw[gi]),
            .o_pulse (w_pulse[gi])
         );
      end
   endgenerate

   assign w_set    = w_pulse[BTN_SET];
   assign w_cancel = w_pulse[BTN_CANCEL];
   assign w_up     = w_pulse[BTN_UP];
   assign w_down   = w_pulse[BTN_DOWN];

   state_t     r_state;
   logic [5:0] r_value;
   logic       r_load;
   logic [1:0] r_addrs;
   logic [5:0] r_data_in;
   logic       r_editing;
   logic [1:0] r_edit_field;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_value      <= '0;
         r_load       <= 1'b0;
         r_addrs      <= FIELD_NONE;
         r_data_in    <= '0;
         r_editing    <= 1'b0;
         r_edit_field <= FIELD_NONE;
      end else begin
         r_load <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_set) begin
                  r_state      <= ST_EDIT_H;
                  r_editing    <= 1'b1;
                  r_edit_field <= FIELD_HR;
                  r_value      <= clamp_value({1'b0, q_hours}, MAX_HR);
               end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
               if (w_cancel) begin
                  r_state      <= ST_IDLE;
                  r_editing    <= 1'b0;
                  r_edit_field <= FIELD_NONE;
                  r_addrs      <= FIELD_NONE;
               end else if (w_set) begin
                  r_state   <= ST_COMMIT;
                  r_load    <= 1'b1;
                  r_addrs   <= r_edit_field;
                  r_data_in <= r_value;
               end else if (w_up ^ w_down) begin
                  r_value <= step_value(r_value, field_max(r_edit_field), w_up);
               end
            end
            ST_COMMIT: begin
               // The next field snapshots the live counter only now, on entry.
               case (r_edit_field)
                  FIELD_HR: begin
                     r_state      <= ST_EDIT_M;
                     r_edit_field <= FIELD_MIN;
                     r_value      <= clamp_value(q_minutes, MAX_SEC_MIN);
                  end
                  FIELD_MIN: begin
                     r_state      <= ST_EDIT_S;
                     r_edit_field <= FIELD_SEC;
                     r_value      <= clamp_value(q_seconds, MAX_SEC_MIN);
                  end
                  default: begin
                     r_state      <= ST_IDLE;
                     r_editing    <= 1'b0;
                     r_edit_field <= FIELD_NONE;
                     r_addrs      <= FIELD_NONE;
                  end
               endcase
            end
            default: begin
               r_state      <= ST_IDLE;
               r_editing    <= 1'b0;
               r_edit_field <= FIELD_NONE;
               r_addrs      <= FIELD_NONE;
            end
         endcase
      end
   end

   assign load       = r_load;
   assign addrs      = r_addrs;
   assign data_in    = r_data_in;
   assign editing    = r_editing;
   assign edit_field = r_edit_field;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected writes are queued, a monitor checks each load strobe.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_set = 1'b0, btn_cancel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [5:0] q_seconds = 6'd0, q_minutes = 6'd0;
   logic [4:0] q_hours = 5'd0;
   logic       load;
   logic [1:0] addrs;
   logic [5:0] data_in;
   logic       editing;
   logic [1:0] edit_field;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   time_set_ctrl #(.DEBOUNCE_CYCLES(4), .DB_CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .btn_set(btn_set), .btn_cancel(btn_cancel), .btn_up(btn_up), .btn_down(btn_down),
      .q_seconds(q_seconds), .q_minutes(q_minutes), .q_hours(q_hours),
      .load(load), .addrs(addrs), .data_in(data_in),
      .editing(editing), .edit_field(edit_field)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Monitor: every load cycle must match the oldest queued write.
   always @(negedge clk) begin
      if (load === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_load: got addrs=%0d data_in=%0d, expected no load", addrs, data_in);
         end else begin
            logic [7:0] exp_w;
            exp_w = sb_q.pop_front();
            check("load_addrs", addrs, exp_w[7:6]);
            check("load_data", data_in, exp_w[5:0]);
            $display("load: addrs=%0d data_in=%0d", addrs, data_in);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int which);
      case (which)
         0: btn_set = 1'b1;
         1: btn_cancel = 1'b1;
         2: btn_up = 1'b1;
         3: btn_down = 1'b1;
         default: begin btn_set = 1'b1; btn_cancel = 1'b1; end
      endcase
      cycles(8);
      btn_set = 1'b0; btn_cancel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      cycles(8);
   endtask

   task automatic expect_write(input logic [1:0] a, input logic [5:0] d);
      sb_q.push_back({a, d});
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_load"}, load, 0);
      check({tag, "_addrs"}, addrs, 3);
      check({tag, "_editing"}, editing, 0);
      check({tag, "_field"}, edit_field, 3);
   endtask

   initial begin
      // 1: reset values and quiet idle
      cycles(3);
      reset = 1'b1;
      cycles(1);
      check_idle("reset");
      check("reset_data", data_in, 0);
      cycles(50);
      check_idle("quiet");
      check("quiet_data", data_in, 0);
      $display("txn: reset and idle");

      // 2/3: hours edit starting at 22
      q_hours = 5'd22; q_minutes = 6'd0; q_seconds = 6'd37;
      press(0);
      check("enter_editing", editing, 1);
      check("enter_field", edit_field, 2);
      btn_up = 1'b1;
      cycles(2);
      btn_up = 1'b0;
      cycles(10);
      btn_up = 1'b1;
      cycles(5);
      check("up_pulse_early", dut.g_db[2].u_db.o_pulse, 0);
      cycles(1);
      check("up_pulse_at_6", dut.g_db[2].u_db.o_pulse, 1);
      cycles(2);
      btn_up = 1'b0;
      cycles(8);
      press(2);
      press(2);
      expect_write(2'b10, 6'd1);
      press(0);
      check("after_hr_field", edit_field, 1);
      check("after_hr_addrs", addrs, 2);
      $display("txn: hours 22 +3 committed");

      // 4: minutes wrap down, then seconds snapshot
      press(3);
      expect_write(2'b01, 6'd59);
      press(0);
      check("after_min_field", edit_field, 0);
      q_seconds = 6'd50;
      expect_write(2'b00, 6'd37);
      press(0);
      check_idle("after_sec");
      check("after_sec_data_hold", data_in, 37);
      $display("txn: minutes 0-1 and seconds snapshot committed");

      // 5: cancel and set together in EDIT_M
      q_hours = 5'd7;
      press(0);
      expect_write(2'b10, 6'd7);
      press(0);
      check("pre_cancel_field", edit_field, 1);
      press(4);
      check_idle("cancel");
      $display("txn: cancel beats set");

      // 6: asynchronous reset during a modified EDIT_S
      press(0);
      expect_write(2'b10, 6'd7);
      press(0);
      expect_write(2'b01, 6'd0);
      press(0);
      press(2);
      check("pre_reset_field", edit_field, 0);
      #2 reset = 1'b0;
      #1;
      check_idle("async_reset");
      check("async_reset_data", data_in, 0);
      cycles(3);
      reset = 1'b1;
      cycles(30);
      check_idle("post_reset");
      check("scoreboard_drained", sb_q.size(), 0);
      $display("txn: reset mid-edit");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-setting front end for the real-time clock.
- Debounces four push buttons and runs an edit FSM: hours, then minutes, then seconds.
- Produces the load/addrs/data_in write interface consumed directly by the seconds/minutes/hours counters.
- Sits upstream of the clock counters. It reads back the current counter values so each edit starts from the displayed time.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable-input cycles required before a button change is accepted (10 ms at 100 MHz)
DB_CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
btn_set  input  1  raw button: enter edit / commit field
btn_cancel  input  1  raw button: abort edit
btn_up  input  1  raw button: increment edited value
btn_down  input  1  raw button: decrement edited value
q_seconds  input  6  current seconds from the counter (0-59)
q_minutes  input  6  current minutes from the counter (0-59)
q_hours  input  5  current hours from the counter (0-23)
load  output  1  one-cycle write strobe to the counters
addrs  output  2  write target: 00 seconds, 01 minutes, 10 hours, 11 none
data_in  output  6  write value, valid when load=1
editing  output  1  high while any EDIT state is active
edit_field  output  2  field being edited (same encoding as addrs); 11 when idle

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, load=0, addrs=11, data_in=0, editing=0, edit_field=11, edit value=0, all debouncers cleared (stable level 0, counter 0).
- Debounce, per button:
  - 2-FF synchronizer.
  - Counter restarts on any change of the synchronized level versus the accepted level.
  - The new level is accepted after DEBOUNCE_CYCLES consecutive cycles of stability.
  - A one-cycle press pulse is emitted on the accepted 0->1 transition.
  - Latency from raw edge to pulse = 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
  - IDLE + set pulse -> EDIT_H; edit value <= q_hours (zero-extended).
  - EDIT_x + up pulse -> value+1, wrapping at the maximum (23->0 for hours, 59->0 for minutes/seconds).
  - EDIT_x + down pulse -> value-1, wrapping at 0 (0->23 for hours, 0->59 for minutes/seconds).
  - EDIT_x + set pulse -> COMMIT: load=1 for exactly one cycle, addrs=field code, data_in=value.
  - After COMMIT: from hours -> EDIT_M with value <= q_minutes; from minutes -> EDIT_S with value <= q_seconds; from seconds -> IDLE.
  - EDIT_x + cancel pulse -> IDLE with no load. Fields already committed stay written.
- Simultaneous pulses in one cycle, priority: cancel > set > up/down.
  - up and down together -> no change.
  - cancel in IDLE -> ignored.
  - up/down in IDLE -> ignored.
- Outputs are registered. load is asserted in the cycle following the set pulse.
- addrs/data_in hold their last committed values after load drops; addrs returns to 11 on entering IDLE.
- The edit value is held in a register and never exceeds the field maximum. Seconds keep counting in the counters during editing; the snapshot is taken only on field entry.
- editing=1 in EDIT_H, EDIT_M, EDIT_S and COMMIT; 0 in IDLE.
- Reset asserted mid-edit: immediate return to reset values; no load is emitted.

Decomposition:
- Shared package holds:
  - Field codes: FIELD_SEC=2'b00, FIELD_MIN=2'b01, FIELD_HR=2'b10, FIELD_NONE=2'b11.
  - MAX_SEC_MIN=59, MAX_HR=23.
  - FSM state encoding.
- Sub-module btn_debounce (synchronizer + counter + edge pulse), parameterized by DEBOUNCE_CYCLES and DB_CNT_W, instantiated four times.

Test Plan (DEBOUNCE_CYCLES=4):
1. Apply reset=0 for 3 cycles, then release -> load=0, addrs=11, data_in=0, editing=0, edit_field=11; 50 cycles with no buttons -> outputs unchanged.
2. Pulse btn_up high for 2 cycles in EDIT_H -> no increment. Hold btn_up for 8 cycles -> exactly one increment, pulse 6 cycles after the raw edge.
3. q_hours=22: press set, then up 3 times, then set -> single load cycle with addrs=10, data_in=1; edit_field becomes 01 and value=q_minutes.
4. q_minutes=0: in EDIT_M press down once, then set -> load with addrs=01, data_in=59. Next, in EDIT_S press set -> load with addrs=00, data_in=q_seconds snapshot; FSM returns to IDLE, editing=0.
5. In EDIT_M press cancel and set in the same debounced cycle -> no load, FSM=IDLE, addrs=11.
6. Assert reset=0 during EDIT_S (value modified) -> outputs return to reset values asynchronously; no load is observed afterwards.
